// File: rtl/aes_inv_cipher_iter.sv
// ============================================================================
// aes_inv_cipher_iter : iterative AES-128 decryption, one inverse round/clock
// Optional abort input enabled by macro AES_INV_ABORT_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ct,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_pt
);

  if (NR != 10) begin : g_nr_check
    $error("aes_inv_cipher_iter supports only NR == 10 (AES-128)");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       fsm_q;
  logic [3:0]   rnd_q;
  logic [127:0] st_q;
  logic         out_valid_q;
  logic [127:0] sub_d;
  logic [127:0] round_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] z;
    z = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(z);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // The last inverse round (rnd 0) skips InvMixColumns.
  always_comb begin
    sub_d   = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_data;
    round_d = (rnd_q == 4'd0) ? sub_d : inv_mix_columns(sub_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      st_q        <= '0;
      out_valid_q <= 1'b0;
    end
`ifdef AES_INV_ABORT_EN
    else if (abort && (fsm_q != IDLE)) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      st_q        <= '0;
      out_valid_q <= 1'b0;
    end
`endif
    else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            st_q  <= in_ct ^ rk_data;
            rnd_q <= 4'(NR - 1);
            fsm_q <= ROUND;
          end
        end
        ROUND: begin
          st_q <= round_d;
          if (rnd_q == 4'd0) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          fsm_q       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_pt    = st_q;
  assign rk_idx    = (fsm_q == IDLE)  ? 4'(NR) :
                     (fsm_q == ROUND) ? rnd_q  : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 known answers, backpressure, busy
// input, mid-round reset and (with AES_INV_ABORT_EN) abort behaviour.
`default_nettype none

module tb_aes_inv_cipher_iter;

  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] key_c [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};
  logic [127:0] key_b [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, ksel;
  logic         abort = 1'b0;
  logic [127:0] in_ct, rk_data, out_pt;
  logic [3:0]   rk_idx;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hs_cnt  = 0;
  int cyc     = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk(clk), .rst(rst),
`ifdef AES_INV_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_ct(in_ct),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pt(out_pt)
  );

  // Expanded-key store answering combinationally.
  always_comb begin
    rk_data = '0;
    if (rk_idx <= 4'd10) rk_data = ksel ? key_b[rk_idx] : key_c[rk_idx];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready && !abort) hs_cnt <= hs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_ct = '0; ksel = 1'b0;
    tick(); tick();
    vec_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      err_cnt++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    vec_cnt++;
    if (out_pt !== 128'h0 || rk_idx !== 4'd10) begin
      err_cnt++; $display("FAIL reset_state: out_pt=%h rk_idx=%0d want 0 10", out_pt, rk_idx);
    end
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_known_answer(input logic ks, input logic [127:0] ct,
                                   input logic [127:0] pt, input string name);
    logic [127:0] exp;
    int hs0;
    ksel = ks; in_ct = ct; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(pt);
    vec_cnt++;
    if (in_ready !== 1'b1 || rk_idx !== 4'd10) begin
      err_cnt++; $display("FAIL %s_accept: in_ready=%b rk_idx=%0d want 1 10", name, in_ready, rk_idx);
    end
    tick();
    in_valid = 1'b0; in_ct = '0;
    for (int i = 1; i <= 10; i++) begin
      vec_cnt++;
      if (rk_idx !== 4'(10 - i) || out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s_round%0d: rk_idx=%0d out_valid=%b want %0d 0", name, i, rk_idx, out_valid, 10 - i);
      end
      tick();
    end
    vec_cnt++;
    if (out_valid !== 1'b1 || rk_idx !== 4'd0) begin
      err_cnt++; $display("FAIL %s_latency: out_valid=%b rk_idx=%0d want 1 0", name, out_valid, rk_idx);
    end
    exp = exp_q.pop_front();
    vec_cnt++;
    if (out_pt !== exp) begin
      err_cnt++; $display("FAIL %s_pt: got %h want %h", name, out_pt, exp);
    end
    hs0 = hs_cnt;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || hs_cnt !== hs0 + 1) begin
      err_cnt++;
      $display("FAIL %s_handshake: out_valid=%b in_ready=%b hs=%0d want 0 1 %0d", name, out_valid, in_ready, hs_cnt, hs0 + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp;
    int n, hs0;
    ksel = 1'b1; in_ct = CT_B; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(PT_B);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    vec_cnt++;
    if (n >= 20) begin
      err_cnt++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid);
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (out_valid !== 1'b1 || out_pt !== exp || in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b pt=%h want 1 0 %h", i, out_valid, in_ready, out_pt, exp);
      end
      tick();
    end
    hs0 = hs_cnt;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vec_cnt++;
    if (hs_cnt !== hs0 + 1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_release: hs=%0d out_valid=%b in_ready=%b want %0d 0 1", hs_cnt, out_valid, in_ready, hs0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    int acc, outs, t_first, t_second, t_last;
    ksel = 1'b0; in_ct = CT_C1; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(PT_C1);
    exp_q.push_back(PT_B);
    acc = 0; outs = 0; t_first = -1; t_second = -1; t_last = -1;
    for (int n = 0; n < 40 && outs < 2; n++) begin
      if (out_valid === 1'b1) begin
        exp = exp_q.pop_front();
        vec_cnt++;
        if (out_pt !== exp) begin
          err_cnt++; $display("FAIL b2b_pt%0d: got %h want %h", outs, out_pt, exp);
        end
        outs++;
        if (outs == 2) t_last = cyc;
      end
      if (outs < 2) begin
        if (in_ready === 1'b1 && in_valid) begin
          if (acc == 0) t_first = cyc;
          else begin ksel = 1'b1; t_second = cyc; end
          acc++;
          tick();
          if (acc == 1) in_ct = CT_B;
          else in_valid = 1'b0;
        end else begin
          tick();
        end
      end
    end
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    vec_cnt++;
    if (outs != 2 || acc != 2) begin
      err_cnt++; $display("FAIL b2b_count: outputs=%0d accepts=%0d want 2 2", outs, acc);
    end
    vec_cnt++;
    if (t_second - t_first != 12 || t_last - t_first != 23) begin
      err_cnt++;
      $display("FAIL b2b_timing: second_accept=+%0d last_out=+%0d want +12 +23", t_second - t_first, t_last - t_first);
    end
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++; $display("FAIL b2b_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midround();
    int n;
    ksel = 1'b0; in_ct = CT_C1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd5 && n < 20) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pt !== 128'h0 || rk_idx !== 4'd10) begin
      err_cnt++;
      $display("FAIL midreset: out_valid=%b in_ready=%b pt=%h rk_idx=%0d want 0 1 0 10", out_valid, in_ready, out_pt, rk_idx);
    end
    test_known_answer(1'b1, CT_B, PT_B, "after_reset");
  endtask

`ifdef AES_INV_ABORT_EN
  task automatic test_abort();
    int n, seen;
    ksel = 1'b0; in_ct = CT_C1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd3 && n < 20) begin tick(); n++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_pt !== 128'h0) begin
      err_cnt++;
      $display("FAIL abort_round: in_ready=%b out_valid=%b pt=%h want 1 0 0", in_ready, out_valid, out_pt);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    vec_cnt++;
    if (seen != 0) begin
      err_cnt++; $display("FAIL abort_no_output: out_valid cycles=%0d want 0", seen);
    end
    ksel = 1'b1; in_ct = CT_B; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    vec_cnt++;
    if (out_pt !== 128'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL abort_done: pt=%h out_valid=%b in_ready=%b want 0 0 1", out_pt, out_valid, in_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known_answer(1'b0, CT_C1, PT_C1, "fips_c1");
    test_known_answer(1'b1, CT_B, PT_B, "fips_b");
    test_backpressure();
    test_back_to_back();
    test_reset_midround();
`ifdef AES_INV_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
